// File: rtl/fb_port_arbiter_if.sv
// Framebuffer port bundle: scanout read channel, frame-writer channel and
// the single-port RAM connection. The arbiter takes the slave view.
interface fb_port_arbiter_if #(
    parameter int AW = 17,
    parameter int DW = 8
) ();
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        output rd_gnt, rd_valid, rd_data, wr_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        input  rd_gnt, rd_valid, rd_data, wr_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: scanout reads have strict priority, a
// refused frame writer eventually forces a bounded write burst. RAM-side
// signals are registered; read data returns in grant order at fixed latency.
module fb_port_arbiter #(
    parameter int AW          = 17,
    parameter int DW          = 8,
    parameter int MEM_LAT     = 1,
    parameter int WR_MAX_WAIT = 8,
    parameter int WR_BURST    = 4
) (
    input  logic             i_clk_pixel,
    input  logic             i_rst,
    fb_port_arbiter_if.slave bus,
    output logic             o_burst_active,
    output logic [15:0]      o_starve_events
);
    localparam logic [7:0] MAX_WAIT  = 8'(WR_MAX_WAIT);
    localparam logic [7:0] BURST_LEN = 8'(WR_BURST);

    typedef enum logic {
        ST_READ_PRIO,
        ST_WR_BURST
    } state_t;

    state_t        state, state_next;
    logic [7:0]    wait_cnt, wait_next;
    logic [7:0]    burst_cnt, burst_next;
    logic          force_wr;
    logic          grant_rd, grant_wr;
    logic          starve_hit;

    logic          mem_en_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [MEM_LAT:0] rd_pipe;
    logic          rd_valid_q;
    logic [DW-1:0] rd_data_q;
    logic          burst_active_q;
    logic [15:0]   starve_q;

    // Grant selection: forced write first, then read, then opportunistic write.
    // Grants are held off during reset so every output reads 0.
    always_comb begin
        force_wr = (state == ST_WR_BURST) || (wait_cnt == MAX_WAIT);
        grant_wr = !i_rst && bus.wr_valid && (force_wr || !bus.rd_req);
        grant_rd = !i_rst && bus.rd_req && !grant_wr;
    end

    assign bus.rd_gnt   = grant_rd;
    assign bus.wr_ready = grant_wr;

    // Next-state, refusal counter and burst counter.
    always_comb begin
        state_next = state;
        burst_next = burst_cnt;
        starve_hit = 1'b0;
        wait_next  = wait_cnt;

        if (grant_wr || !bus.wr_valid) begin
            wait_next = '0;
        end else if (wait_cnt != MAX_WAIT) begin
            wait_next = wait_cnt + 8'd1;
        end

        case (state)
            ST_READ_PRIO: begin
                if (grant_wr && (wait_cnt == MAX_WAIT)) begin
                    starve_hit = 1'b1;
                    // The forcing grant is burst grant 1; a one-grant burst
                    // is already complete, so the FSM never leaves READ_PRIO.
                    if (BURST_LEN != 8'd1) begin
                        state_next = ST_WR_BURST;
                        burst_next = 8'd1;
                    end
                end
            end
            ST_WR_BURST: begin
                if (!bus.wr_valid) begin
                    state_next = ST_READ_PRIO;
                    burst_next = '0;
                end else if (grant_wr) begin
                    if (burst_cnt + 8'd1 == BURST_LEN) begin
                        state_next = ST_READ_PRIO;
                        burst_next = '0;
                    end else begin
                        burst_next = burst_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_next = ST_READ_PRIO;
                burst_next = '0;
            end
        endcase
    end

    // FSM state and counters.
    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            state     <= ST_READ_PRIO;
            wait_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_next;
            burst_cnt <= burst_next;
        end
    end

    // RAM command register; address and write data hold when idle.
    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q <= grant_rd || grant_wr;
            mem_we_q <= grant_wr;
            if (grant_wr) begin
                mem_addr_q  <= bus.wr_addr;
                mem_wdata_q <= bus.wr_data;
            end else if (grant_rd) begin
                mem_addr_q  <= bus.rd_addr;
            end
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Read-return tracking: bit k marks a read whose RAM access is k cycles
    // past issue; the top bit lines up with valid i_mem_rdata.
    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            rd_pipe    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_pipe    <= {rd_pipe[MEM_LAT-1:0], grant_rd};
            rd_valid_q <= rd_pipe[MEM_LAT];
            if (rd_pipe[MEM_LAT]) begin
                rd_data_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

    // Burst flag marks RAM cycles carrying a forced write, so it spans the
    // forcing grant through the last burst write as seen on the memory port.
    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            burst_active_q <= 1'b0;
        end else begin
            burst_active_q <= grant_wr && force_wr;
        end
    end

    // Saturating count of forced bursts.
    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            starve_q <= '0;
        end else if (starve_hit && (starve_q != '1)) begin
            starve_q <= starve_q + 16'd1;
        end
    end

    assign o_burst_active  = burst_active_q;
    assign o_starve_events = starve_q;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed vector table for the reset, read
// stream, lone write, starvation, early exit and reset-in-flight cases,
// then randomized traffic against a counting reference model.
module tb_fb_port_arbiter;
    localparam int AW     = 17;
    localparam int DW     = 8;
    localparam int WMAX   = 8;
    localparam int WBURST = 4;
    localparam int RAM_WORDS = 1 << AW;

    logic clk;
    logic rst;
    logic ram_init;
    logic o_burst_active;
    logic [15:0] o_starve_events;

    fb_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    fb_port_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(1), .WR_MAX_WAIT(WMAX), .WR_BURST(WBURST)
    ) dut (
        .i_clk_pixel     (clk),
        .i_rst           (rst),
        .bus             (bus),
        .o_burst_active  (o_burst_active),
        .o_starve_events (o_starve_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM, one cycle read latency, read-before-write.
    logic [7:0] ram [RAM_WORDS];
    logic [7:0] rdata_q;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < RAM_WORDS; i++) ram[i] <= 8'(i) ^ 8'h5A;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            rdata_q <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rdata_q;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string      tag;
        bit         rst;
        bit         rd_req;
        logic [16:0] rd_addr;
        bit         wr_valid;
        logic [16:0] wr_addr;
        logic [7:0] wr_data;
        bit         chk_reg;
        bit         e_rd_gnt, e_wr_ready, e_mem_en, e_mem_we, e_rd_valid, e_burst;
        logic [15:0] e_starve;
        bit         chk_data;
        logic [7:0] e_rd_data;
        bit         chk_mem;
        logic [16:0] e_mem_addr;
        logic [7:0] e_mem_wdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add_row(input string tag, input bit r, input bit rq, input int ra,
                           input bit wv, input int wa, input int wd, input bit creg,
                           input bit g, input bit wr, input bit en, input bit we,
                           input bit rv, input bit ba, input int st,
                           input bit cd, input int rdd);
        vec_t v;
        v.tag = tag; v.rst = r; v.rd_req = rq; v.rd_addr = 17'(ra);
        v.wr_valid = wv; v.wr_addr = 17'(wa); v.wr_data = 8'(wd);
        v.chk_reg = creg; v.e_rd_gnt = g; v.e_wr_ready = wr; v.e_mem_en = en;
        v.e_mem_we = we; v.e_rd_valid = rv; v.e_burst = ba; v.e_starve = 16'(st);
        v.chk_data = cd; v.e_rd_data = 8'(rdd);
        v.chk_mem = 1'b0; v.e_mem_addr = '0; v.e_mem_wdata = '0;
        vecs.push_back(v);
    endtask

    task automatic set_mem(input int a, input int d);
        vecs[vecs.size()-1].chk_mem     = 1'b1;
        vecs[vecs.size()-1].e_mem_addr  = 17'(a);
        vecs[vecs.size()-1].e_mem_wdata = 8'(d);
    endtask

    // Two reset cycles with both requesters active: no grants, and after the
    // first reset edge every registered output is 0.
    task automatic add_reset(input string tag);
        add_row({tag, "_rst0"}, 1, 1, 5, 1, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_row({tag, "_rst1"}, 1, 1, 5, 1, 6, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        set_mem(0, 0);
    endtask

    task automatic build_table();
        int p;
        bit g, w, en, we, rv;
        // Starvation: both requesters held; 8 reads, forced burst of 4 writes.
        add_reset("starve");
        for (int c = 0; c <= 24; c++) begin
            p  = c % 12;
            g  = (p < 8);
            w  = (p >= 8);
            en = (c >= 1);
            we = (c >= 1) && ((c - 1) % 12 >= 8);
            rv = (c >= 3) && ((c - 3) % 12 < 8);
            add_row("starve", 0, 1, c, 1, 'h300, c + 1, 1, g, w, en, we, rv, we,
                    (c >= 21) ? 2 : ((c >= 9) ? 1 : 0), rv, (c - 3) ^ 'h5A);
        end
        // Read stream, addresses 0..4.
        add_reset("rdstream");
        for (int c = 0; c <= 8; c++) begin
            rv = (c >= 3) && (c <= 7);
            add_row("rdstream", 0, c <= 4, c, 0, 0, 0, 1, c <= 4, 0,
                    (c >= 1) && (c <= 5), 0, rv, 0, 0, rv, (c - 3) ^ 'h5A);
        end
        // Lone write, then read it back; addr/wdata hold while idle.
        add_reset("lonewr");
        add_row("lonewr", 0, 0, 0, 1, 'h100, 'hAA, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add_row("lonewr", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        set_mem('h100, 'hAA);
        add_row("lonewr", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_mem('h100, 'hAA);
        add_row("lonewr", 0, 1, 'h100, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_row("lonewr", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        set_mem('h100, 'hAA);
        add_row("lonewr", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_row("lonewr", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 'hAA);
        // Burst early exit: write request drops in cycle 10.
        add_reset("early");
        for (int c = 0; c <= 13; c++) begin
            w  = (c == 8) || (c == 9);
            we = (c == 9) || (c == 10);
            rv = (c >= 3) && (c != 11) && (c != 12);
            add_row("early", 0, 1, c, c < 10, 'h300, 'h40 + c, 1, !w, w, c >= 1, we, rv, we,
                    (c >= 9) ? 1 : 0, rv, (c - 3) ^ 'h5A);
        end
        // Reset while three reads are in flight.
        add_reset("rstfly");
        for (int c = 0; c <= 2; c++)
            add_row("rstfly", 0, 1, c, 0, 0, 0, 1, 1, 0, c >= 1, 0, 0, 0, 0, 0, 0);
        add_row("rstfly", 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 'h5A);
        for (int c = 4; c <= 6; c++)
            add_row("rstfly", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    // Reference model for random traffic.
    typedef struct { int due; logic [7:0] data; } rd_exp_t;
    rd_exp_t rq[$];
    logic [7:0] sh [32];
    int  m_refused, m_burst_left, m_starve;
    bit  e_en, e_we, e_burst;
    logic [16:0] e_addr;
    logic [7:0]  e_wdata, e_rdata;

    initial begin
        vec_t v;
        bit in_burst, forced, wg, rg, exp_rv;
        int wr_pct;
        logic [4:0] ra, wa;

        rst = 1'b1; ram_init = 1'b1;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        @(posedge clk); #1;
        ram_init = 1'b0;

        build_table();
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            rst = v.rst;
            bus.rd_req = v.rd_req; bus.rd_addr = v.rd_addr;
            bus.wr_valid = v.wr_valid; bus.wr_addr = v.wr_addr; bus.wr_data = v.wr_data;
            @(negedge clk);
            chk($sformatf("%s[%0d] rd_gnt", v.tag, i), 32'(bus.rd_gnt), 32'(v.e_rd_gnt));
            chk($sformatf("%s[%0d] wr_ready", v.tag, i), 32'(bus.wr_ready), 32'(v.e_wr_ready));
            if (v.chk_reg) begin
                chk($sformatf("%s[%0d] mem_en", v.tag, i), 32'(bus.mem_en), 32'(v.e_mem_en));
                chk($sformatf("%s[%0d] mem_we", v.tag, i), 32'(bus.mem_we), 32'(v.e_mem_we));
                chk($sformatf("%s[%0d] rd_valid", v.tag, i), 32'(bus.rd_valid), 32'(v.e_rd_valid));
                chk($sformatf("%s[%0d] burst_active", v.tag, i), 32'(o_burst_active), 32'(v.e_burst));
                chk($sformatf("%s[%0d] starve_events", v.tag, i), 32'(o_starve_events), 32'(v.e_starve));
            end
            if (v.chk_data)
                chk($sformatf("%s[%0d] rd_data", v.tag, i), 32'(bus.rd_data), 32'(v.e_rd_data));
            if (v.chk_mem) begin
                chk($sformatf("%s[%0d] mem_addr", v.tag, i), 32'(bus.mem_addr), 32'(v.e_mem_addr));
                chk($sformatf("%s[%0d] mem_wdata", v.tag, i), 32'(bus.mem_wdata), 32'(v.e_mem_wdata));
            end
            @(posedge clk); #1;
        end

        // Random traffic on addresses 0..31 (untouched by the directed part).
        rst = 1'b1; bus.rd_req = 1'b0; bus.wr_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) sh[i] = 8'(i) ^ 8'h5A;
        m_refused = 0; m_burst_left = 0; m_starve = 0;
        e_en = 0; e_we = 0; e_burst = 0; e_addr = '0; e_wdata = '0; e_rdata = '0;
        rq.delete();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            wr_pct = ((cyc / 200) % 2 == 1) ? 95 : 40;
            ra = 5'($urandom_range(0, 31));
            wa = 5'($urandom_range(0, 31));
            bus.rd_req   = ($urandom_range(0, 99) < 85);
            bus.rd_addr  = 17'(ra);
            bus.wr_valid = ($urandom_range(0, 99) < wr_pct);
            bus.wr_addr  = 17'(wa);
            bus.wr_data  = 8'($urandom);

            in_burst = (m_burst_left > 0);
            forced   = in_burst || (m_refused >= WMAX);
            wg = bus.wr_valid && (forced || !bus.rd_req);
            rg = bus.rd_req && !wg;
            exp_rv = (rq.size() > 0) && (rq[0].due == cyc);
            if (exp_rv) begin
                e_rdata = rq[0].data;
                void'(rq.pop_front());
            end

            @(negedge clk);
            chk("rnd rd_gnt", 32'(bus.rd_gnt), 32'(rg));
            chk("rnd wr_ready", 32'(bus.wr_ready), 32'(wg));
            chk("rnd mem_en", 32'(bus.mem_en), 32'(e_en));
            chk("rnd mem_we", 32'(bus.mem_we), 32'(e_we));
            chk("rnd mem_addr", 32'(bus.mem_addr), 32'(e_addr));
            chk("rnd mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
            chk("rnd rd_valid", 32'(bus.rd_valid), 32'(exp_rv));
            chk("rnd rd_data", 32'(bus.rd_data), 32'(e_rdata));
            chk("rnd burst_active", 32'(o_burst_active), 32'(e_burst));
            chk("rnd starve_events", 32'(o_starve_events), 32'(m_starve));

            e_en = rg || wg;
            e_we = wg;
            e_burst = wg && forced;
            if (wg) begin
                e_addr = 17'(wa); e_wdata = bus.wr_data; sh[wa] = bus.wr_data;
                if (in_burst) m_burst_left--;
                else if (m_refused >= WMAX) begin
                    if (m_starve < 65535) m_starve++;
                    m_burst_left = WBURST - 1;
                end
                m_refused = 0;
            end else begin
                if (rg) begin
                    e_addr = 17'(ra);
                    rq.push_back('{cyc + 3, sh[ra]});
                end
                if (bus.wr_valid) begin
                    if (m_refused < WMAX) m_refused++;
                end else begin
                    m_refused = 0;
                    m_burst_left = 0;
                end
            end
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
